frame_fifo: RTL and testbench
=============================

Name: frame_fifo

Overview:
- Parametrised successor frame store between the TPIU frame collector and the output handler.
- Holds WIDTH-bit frames in a circular buffer and presents the oldest first-word-fall-through.
- Full policy is selectable: post-mortem overwrite of the oldest frame, or drop of the newest.
- Adds freeze, flush, a programmable high watermark, a sticky overflow flag and saturating statistics.

Parameters:
- WIDTH, 128, frame width in bits.
- DEPTHLOG2, 9, log2 of capacity; all 2^DEPTHLOG2 entries are usable.
- OVERWRITE, 1, 1 = discard oldest when full; 0 = discard incoming when full.
- TOGGLE_IN, 1, 1 = FrAvail is an asynchronous toggle (each edge is one frame); 0 = FrAvail is a single-cycle clk-domain strobe.
- STRETCH, 26, width of the data-indication stretch counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active low.
- FrAvail  in  1  frame-available toggle or strobe (per TOGGLE_IN).
- FrameIn  in  WIDTH  frame, stable while FrAvail signals.
- Freeze  in  1  level; while 1, incoming frames are not stored.
- Flush  in  1  single-cycle; empties the buffer.
- HighMark  in  DEPTHLOG2+1  watermark threshold.
- FrameOut  out  WIDTH  oldest frame, valid when FrameValid.
- FrameValid  out  1  FrameOut holds a frame.
- FrameNext  in  1  pop; acts only when FrameValid=1.
- FramesCnt  out  DEPTHLOG2+1  stored frames, including the presented one.
- Full  out  1  FramesCnt == 2^DEPTHLOG2.
- AboveMark  out  1  FramesCnt >= HighMark.
- DataOverf  out  1  sticky: a frame was lost since the last reset or Flush.
- DataInd  out  1  stretched indication that data is arriving.
- TotalFrames  out  32  frames offered (wraps).
- LostFrames  out  16  frames lost (saturates at 16'hFFFF).

Behaviour:
- Reset (rst=0 at an edge): all pointers, FramesCnt, FrameValid, Full, AboveMark, DataOverf, DataInd, TotalFrames and LostFrames go to 0. The synchroniser is cleared; FrameOut is don't-care. Reset mid-operation discards all contents.
- Write event (wr):
  - TOGGLE_IN=1: FrAvail passes a 2-flop synchroniser plus an edge register; wr = any edge of the synchronised signal. Wr fires on the 3rd clk edge after the toggle.
  - TOGGLE_IN=0: wr = FrAvail sampled at the edge.
- Every wr: TotalFrames+1; DataInd stretch counter reloads to all ones and decrements each cycle toward 0; DataInd = counter != 0.
- Storing a wr:
  - Freeze=1: frame not stored; LostFrames+1; DataOverf set.
  - Not full, or full with an accepted pop in the same cycle: frame stored; no loss.
  - Full, no pop, OVERWRITE=1: oldest frame discarded and the new one stored; FramesCnt unchanged; LostFrames+1; DataOverf set. FrameOut advances to the next-oldest frame, and FrameValid stays 1.
  - Full, no pop, OVERWRITE=0: new frame dropped; LostFrames+1; DataOverf set.
- Pop: FrameNext=1 with FrameValid=1 removes the presented frame. FrameNext while FrameValid=0 is ignored.
  - Sustained FrameNext with frames stored delivers one frame per cycle, with no bubbles.
- Latency: with the buffer empty and a wr at edge E, FrameValid=1 and FrameOut=that frame after edge E+2. FramesCnt increments after edge E+1.
- Flush at edge E: after E, FramesCnt=0, FrameValid=0 and DataOverf=0. A same-cycle pop is ignored. A same-cycle wr counts in TotalFrames only; it is not stored and not counted as lost. Statistics are otherwise retained.
- Counting:
  - FramesCnt, Full and AboveMark are registered and exact after each edge, except for the latency rule above.
  - Pointers are DEPTHLOG2+1 bits; the extra bit disambiguates full from empty across wrap-around.
- Memory: simple dual-port, registered read; inferrable as block RAM.

Test Plan:
- Strobe mode, DEPTHLOG2=2: write 0xA1 at edge E -> FrameValid=1 and FrameOut=0xA1 after E+2; pop -> FrameValid=0, FramesCnt=0.
- Write 4 frames 1..4, then a 5th with OVERWRITE=1 -> FramesCnt=4, Full=1, LostFrames=1, DataOverf=1; pops return 2,3,4,5.
- Same fill with OVERWRITE=0 -> pops return 1,2,3,4; LostFrames=1.
- Full buffer with simultaneous write 9 and pop -> LostFrames unchanged, FramesCnt=4, last frame popped is 9.
- Write 6 frames, popping continuously so the pointers wrap; HighMark=3 -> AboveMark tracks FramesCnt>=3; data order preserved.
- Toggle mode: FrAvail toggles 3 times, 8 cycles apart -> TotalFrames=3. Then Freeze=1 with 1 toggle -> LostFrames=1. Then Flush -> FramesCnt=0, DataOverf=0, TotalFrames=4. Then rst=0 for one edge -> all outputs 0.

Source files
------------

// File: rtl/frame_fifo.sv
// rtl/frame_fifo.sv - frame store with FWFT output, overwrite/drop full policy and statistics
module frame_fifo #(
  parameter int WIDTH     = 128,
  parameter int DEPTHLOG2 = 9,
  parameter int OVERWRITE = 1,
  parameter int TOGGLE_IN = 1,
  parameter int STRETCH   = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 FrAvail,
  input  logic [WIDTH-1:0]     FrameIn,
  input  logic                 Freeze,
  input  logic                 Flush,
  input  logic [DEPTHLOG2:0]   HighMark,
  output logic [WIDTH-1:0]     FrameOut,
  output logic                 FrameValid,
  input  logic                 FrameNext,
  output logic [DEPTHLOG2:0]   FramesCnt,
  output logic                 Full,
  output logic                 AboveMark,
  output logic                 DataOverf,
  output logic                 DataInd,
  output logic [31:0]          TotalFrames,
  output logic [15:0]          LostFrames
);

  localparam int PW    = DEPTHLOG2 + 1;
  localparam int DEPTH = 1 << DEPTHLOG2;
  localparam logic [DEPTHLOG2:0] FULL_CNT = {1'b1, {DEPTHLOG2{1'b0}}};

  logic wr;

  generate
    if (TOGGLE_IN != 0) begin : g_toggle
      logic sync1_q, sync2_q, edge_q;
      // Two-flop synchroniser plus edge register; every edge of the toggle is one frame
      always_ff @(posedge clk) begin
        if (!rst) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          edge_q  <= 1'b0;
        end else begin
          sync1_q <= FrAvail;
          sync2_q <= sync1_q;
          edge_q  <= sync2_q;
        end
      end
      assign wr = sync2_q ^ edge_q;
    end else begin : g_strobe
      assign wr = FrAvail;
    end
  endgenerate

  logic             stg_vld_q;
  logic [WIDTH-1:0] stg_data_q;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, cnt_q, cnt_d, avail;
  logic             valid_q, valid_d, full_q, above_q, overf_q, overf_d;
  logic [31:0]      total_q, total_d;
  logic [15:0]      lost_q, lost_d;
  logic [16:0]      lost_sum;
  logic [STRETCH-1:0] str_q, str_d;
  logic             pop, st, store, discard, full_loss, freeze_loss, adv;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] out_q;

  // Staging data register: the frame waits here one cycle before entering memory
  always_ff @(posedge clk) begin
    stg_data_q <= FrameIn;
  end

  // Store decision, pointer/count arithmetic and statistics next-state
  always_comb begin
    pop         = FrameNext && valid_q && !Flush;
    st          = stg_vld_q && !Flush;
    freeze_loss = wr && Freeze && !Flush;
    store       = 1'b0;
    discard     = 1'b0;
    full_loss   = 1'b0;
    if (st) begin
      if (!full_q || pop) begin
        store = 1'b1;
      end else if (OVERWRITE != 0) begin
        store     = 1'b1;
        discard   = 1'b1;
        full_loss = 1'b1;
      end else begin
        full_loss = 1'b1;
      end
    end
    adv     = pop || discard;
    // Frames already in memory before this edge decide validity, which
    // gives the two-cycle write-to-valid latency and avoids read/write collision.
    avail   = cnt_q - PW'(adv);
    valid_d = !Flush && (avail != '0);
    wptr_d  = Flush ? '0 : wptr_q + PW'(store);
    rptr_d  = Flush ? '0 : rptr_q + PW'(adv);
    cnt_d   = Flush ? '0 : cnt_q + PW'(store) - PW'(adv);
    overf_d = Flush ? 1'b0 : (overf_q | freeze_loss | full_loss);
    total_d = total_q + 32'(wr);
    lost_sum = {1'b0, lost_q} + 17'(freeze_loss) + 17'(full_loss);
    lost_d  = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
    if (wr) begin
      str_d = '1;
    end else if (str_q != '0) begin
      str_d = str_q - STRETCH'(1);
    end else begin
      str_d = str_q;
    end
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      stg_vld_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      full_q    <= 1'b0;
      above_q   <= 1'b0;
      overf_q   <= 1'b0;
      total_q   <= '0;
      lost_q    <= '0;
      str_q     <= '0;
    end else begin
      stg_vld_q <= wr && !Flush && !Freeze;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      full_q    <= (cnt_d == FULL_CNT);
      above_q   <= (cnt_d >= HighMark);
      overf_q   <= overf_d;
      total_q   <= total_d;
      lost_q    <= lost_d;
      str_q     <= str_d;
    end
  end

  // Simple dual-port memory with registered read of the next head entry
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wptr_q[DEPTHLOG2-1:0]] <= stg_data_q;
    end
    out_q <= mem[rptr_d[DEPTHLOG2-1:0]];
  end

  assign FrameOut    = out_q;
  assign FrameValid  = valid_q;
  assign FramesCnt   = cnt_q;
  assign Full        = full_q;
  assign AboveMark   = above_q;
  assign DataOverf   = overf_q;
  assign DataInd     = (str_q != '0);
  assign TotalFrames = total_q;
  assign LostFrames  = lost_q;

endmodule

// File: tb/tb_frame_fifo.sv
// tb/tb_frame_fifo.sv - scoreboard bench for frame_fifo in strobe and toggle modes
module tb_frame_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s_av, s_frz, s_fl, s_next;
  logic [7:0] s_din;
  logic [2:0] hm;
  logic       t_av, t_frz, t_fl, t_next;
  logic [7:0] t_din;

  logic [7:0]  a_out, b_out, c_out;
  logic        a_vld, b_vld, c_vld, a_full, b_full, c_full;
  logic        a_above, b_above, c_above, a_ovf, b_ovf, c_ovf, a_ind, b_ind, c_ind;
  logic [2:0]  a_cnt, b_cnt, c_cnt;
  logic [31:0] a_tot, b_tot, c_tot;
  logic [15:0] a_lost, b_lost, c_lost;

  frame_fifo #(.WIDTH(8), .DEPTHLOG2(2), .OVERWRITE(1), .TOGGLE_IN(0), .STRETCH(4)) u_a (
    .clk(clk), .rst(rst), .FrAvail(s_av), .FrameIn(s_din), .Freeze(s_frz), .Flush(s_fl),
    .HighMark(hm), .FrameOut(a_out), .FrameValid(a_vld), .FrameNext(s_next),
    .FramesCnt(a_cnt), .Full(a_full), .AboveMark(a_above), .DataOverf(a_ovf),
    .DataInd(a_ind), .TotalFrames(a_tot), .LostFrames(a_lost));

  frame_fifo #(.WIDTH(8), .DEPTHLOG2(2), .OVERWRITE(0), .TOGGLE_IN(0), .STRETCH(4)) u_b (
    .clk(clk), .rst(rst), .FrAvail(s_av), .FrameIn(s_din), .Freeze(s_frz), .Flush(s_fl),
    .HighMark(hm), .FrameOut(b_out), .FrameValid(b_vld), .FrameNext(s_next),
    .FramesCnt(b_cnt), .Full(b_full), .AboveMark(b_above), .DataOverf(b_ovf),
    .DataInd(b_ind), .TotalFrames(b_tot), .LostFrames(b_lost));

  frame_fifo #(.WIDTH(8), .DEPTHLOG2(2), .OVERWRITE(1), .TOGGLE_IN(1), .STRETCH(4)) u_c (
    .clk(clk), .rst(rst), .FrAvail(t_av), .FrameIn(t_din), .Freeze(t_frz), .Flush(t_fl),
    .HighMark(hm), .FrameOut(c_out), .FrameValid(c_vld), .FrameNext(t_next),
    .FramesCnt(c_cnt), .Full(c_full), .AboveMark(c_above), .DataOverf(c_ovf),
    .DataInd(c_ind), .TotalFrames(c_tot), .LostFrames(c_lost));

  int total = 0;
  int bad = 0;
  logic [7:0] qa[$], qb[$], qc[$];
  int tot_s = 0;
  int lost_a = 0;
  int lost_b = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_s(input logic [7:0] d);
    logic [7:0] tmp;
    s_av  = 1'b1;
    s_din = d;
    tot_s++;
    if (qa.size() == 4) begin
      tmp = qa.pop_front();
      lost_a++;
    end
    qa.push_back(d);
    if (qb.size() == 4) lost_b++;
    else qb.push_back(d);
    @(negedge clk);
    s_av = 1'b0;
  endtask

  task automatic pop_s(input string tag);
    logic [7:0] ea, eb;
    ea = (qa.size() > 0) ? qa.pop_front() : 8'hxx;
    eb = (qb.size() > 0) ? qb.pop_front() : 8'hxx;
    chk({tag, ".va"}, a_vld, 1);
    chk({tag, ".da"}, a_out, ea);
    chk({tag, ".vb"}, b_vld, 1);
    chk({tag, ".db"}, b_out, eb);
    s_next = 1'b1;
    @(negedge clk);
    s_next = 1'b0;
  endtask

  task automatic tog(input logic [7:0] d);
    t_din = d;
    t_av  = ~t_av;
    idle(8);
  endtask

  initial begin
    logic [7:0] ea, eb;
    rst = 1'b0;
    s_av = 0; s_frz = 0; s_fl = 0; s_next = 0; s_din = 0; hm = 3'd3;
    t_av = 0; t_frz = 0; t_fl = 0; t_next = 0; t_din = 0;
    idle(2);
    chk("rst.cnt", a_cnt, 0);
    chk("rst.vld", a_vld, 0);
    chk("rst.full", a_full, 0);
    chk("rst.above", a_above, 0);
    chk("rst.ovf", a_ovf, 0);
    chk("rst.tot", a_tot, 0);
    chk("rst.lost", c_lost, 0);
    rst = 1'b1;
    idle(2);

    // first-frame latency
    wr_s(8'hA1);
    chk("lat.cnt1", a_cnt, 0);
    idle(1);
    chk("lat.cnt2", a_cnt, 1);
    chk("lat.vld2", a_vld, 0);
    idle(1);
    chk("lat.ind", a_ind, 1);
    pop_s("lat");
    chk("lat.vld_after", a_vld, 0);
    chk("lat.cnt_after", a_cnt, 0);

    // fill plus one: overwrite vs drop
    for (int i = 1; i <= 5; i++) wr_s(8'(i));
    idle(2);
    chk("ovw.cnt", a_cnt, 4);
    chk("ovw.full", a_full, 1);
    chk("ovw.lost", a_lost, lost_a);
    chk("ovw.ovf", a_ovf, 1);
    chk("drop.cnt", b_cnt, 4);
    chk("drop.lost", b_lost, lost_b);
    chk("drop.ovf", b_ovf, 1);
    for (int i = 0; i < 4; i++) pop_s("fill");
    chk("fill.cnt", a_cnt, 0);
    chk("fill.vld", a_vld, 0);
    chk("fill.full", a_full, 0);

    // full buffer, store of 9 coincides with a pop
    for (int i = 5; i <= 8; i++) wr_s(8'(i));
    idle(2);
    chk("w9.full", b_full, 1);
    s_av = 1'b1; s_din = 8'd9; tot_s++;
    @(negedge clk);
    s_av = 1'b0;
    pop_s("w9p");
    qa.push_back(8'd9);
    qb.push_back(8'd9);
    idle(2);
    chk("w9.cnt", a_cnt, 4);
    chk("w9.lost_a", a_lost, lost_a);
    chk("w9.lost_b", b_lost, lost_b);
    for (int i = 0; i < 4; i++) pop_s("w9");
    idle(20);
    chk("ind.off", a_ind, 0);

    // watermark and wrap with continuous popping
    wr_s(8'h10); wr_s(8'h11); wr_s(8'h12);
    idle(2);
    chk("wm.cnt3", a_cnt, 3);
    chk("wm.above3", a_above, 1);
    pop_s("wm");
    chk("wm.above2", a_above, 0);
    hm = 3'd2;
    idle(1);
    chk("wm.hm2", a_above, 1);
    hm = 3'd3;
    for (int i = 0; i < 12; i++) begin
      if (i < 3) begin
        s_av = 1'b1; s_din = 8'h13 + 8'(i); tot_s++;
        qa.push_back(s_din); qb.push_back(s_din);
      end else begin
        s_av = 1'b0;
      end
      if (a_vld) begin
        ea = (qa.size() > 0) ? qa.pop_front() : 8'hxx;
        eb = (qb.size() > 0) ? qb.pop_front() : 8'hxx;
        chk("wrap.da", a_out, ea);
        chk("wrap.db", b_out, eb);
        s_next = 1'b1;
      end else begin
        s_next = 1'b0;
      end
      @(negedge clk);
    end
    s_av = 1'b0; s_next = 1'b0;
    chk("wrap.cnt", a_cnt, 0);
    chk("wrap.vld", a_vld, 0);
    chk("wrap.above", a_above, 0);
    chk("wrap.tot", a_tot, tot_s);

    // flush with a same-cycle write
    wr_s(8'h50);
    idle(2);
    chk("fl.cnt1", a_cnt, 1);
    s_av = 1'b1; s_din = 8'h51; s_fl = 1'b1; tot_s++;
    @(negedge clk);
    s_av = 1'b0; s_fl = 1'b0;
    qa.delete(); qb.delete();
    idle(2);
    chk("fl.cnt", a_cnt, 0);
    chk("fl.vld", a_vld, 0);
    chk("fl.ovf_a", a_ovf, 0);
    chk("fl.ovf_b", b_ovf, 0);
    chk("fl.lost", a_lost, lost_a);
    chk("fl.tot", a_tot, tot_s);

    // toggle mode
    tog(8'h31); qc.push_back(8'h31);
    tog(8'h32); qc.push_back(8'h32);
    tog(8'h33); qc.push_back(8'h33);
    chk("tog.tot", c_tot, 3);
    chk("tog.cnt", c_cnt, 3);
    chk("tog.vld", c_vld, 1);
    chk("tog.out", c_out, qc[0]);
    t_frz = 1'b1;
    tog(8'h34);
    t_frz = 1'b0;
    chk("frz.lost", c_lost, 1);
    chk("frz.ovf", c_ovf, 1);
    chk("frz.cnt", c_cnt, 3);
    t_fl = 1'b1;
    @(negedge clk);
    t_fl = 1'b0;
    qc.delete();
    chk("tfl.cnt", c_cnt, 0);
    chk("tfl.ovf", c_ovf, 0);
    chk("tfl.vld", c_vld, 0);
    chk("tfl.tot", c_tot, 4);
    chk("tfl.lost", c_lost, 1);

    // reset mid-operation
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst2.c_tot", c_tot, 0);
    chk("rst2.c_lost", c_lost, 0);
    chk("rst2.c_ind", c_ind, 0);
    chk("rst2.a_tot", a_tot, 0);
    chk("rst2.a_lost", a_lost, 0);
    chk("rst2.b_lost", b_lost, 0);
    chk("rst2.a_cnt", a_cnt, 0);
    chk("rst2.c_full", c_full, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
